dmem_arbiter: RTL and testbench

Shares the single-port 4096×32 data memory between the pipeline's memory stage and an I/O requester (loader/debug/peripheral port). Grants at most one access per cycle, CPU first by default, with a bounded-starvation rule for the I/O port. Stalls the pipeline when the CPU loses a cycle and routes the registered read data back to its owner. Sits between the memory stage and the dmem instance.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter.sv | 102 ++++++++++
 tb/tb_dmem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Processor-wide data-memory constants and the read-ownership encoding
// shared by the memory stage, the arbiter and the bench.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 12;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnCpu  = 2'd1,
    OwnIo   = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between the memory stage and an I/O requester.
// CPU wins by default; I/O is forced a slot after IO_STARVE_MAX lost cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned IO_STARVE_MAX = 4
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   cpu_req,
  input  logic                   cpu_wren,
  input  logic [DMEM_ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0]      cpu_d,
  output logic                   cpu_stall,
  output logic                   cpu_rvalid,
  output logic [WORD_W-1:0]      cpu_q,

  input  logic                   io_req,
  input  logic                   io_wren,
  input  logic [DMEM_ADDR_W-1:0] io_addr,
  input  logic [WORD_W-1:0]      io_d,
  output logic                   io_ack,
  output logic                   io_rvalid,
  output logic [WORD_W-1:0]      io_q,

  output logic [DMEM_ADDR_W-1:0] address_dmem,
  output logic [WORD_W-1:0]      d_dmem,
  output logic                   wren,
  input  logic [WORD_W-1:0]      q_dmem
);

  localparam logic [3:0] StarveMax = 4'(IO_STARVE_MAX);

  logic [3:0] starve_q, starve_d;
  rd_owner_e  rd_owner_q, rd_owner_d;
  logic       grant_cpu, grant_io;

  always_comb begin
    grant_cpu = 1'b0;
    grant_io  = 1'b0;
    if (!reset) begin
      if (io_req && (!cpu_req || (starve_q >= StarveMax))) begin
        grant_io = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end
    end
  end

  // With no grant the mux rests on the CPU side; only wren must be forced low.
  always_comb begin
    address_dmem = cpu_addr;
    d_dmem       = cpu_d;
    wren         = 1'b0;
    if (grant_io) begin
      address_dmem = io_addr;
      d_dmem       = io_d;
      wren         = io_wren;
    end else if (grant_cpu) begin
      wren         = cpu_wren;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!io_req || grant_io) begin
      starve_d = 4'd0;
    end else if (grant_cpu && (starve_q < StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (grant_io && !io_wren) begin
      rd_owner_d = OwnIo;
    end else if (grant_cpu && !cpu_wren) begin
      rd_owner_d = OwnCpu;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q   <= 4'd0;
      rd_owner_q <= OwnNone;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign cpu_stall = cpu_req & ~grant_cpu & ~reset;
  assign io_ack    = grant_io;

  // Gating with reset discards a read that was granted just before reset rose.
  assign cpu_rvalid = ~reset & (rd_owner_q == OwnCpu);
  assign io_rvalid  = ~reset & (rd_owner_q == OwnIo);
  assign cpu_q      = q_dmem;
  assign io_q       = q_dmem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 4096x32 registered dmem.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset;
  logic        cpu_req, cpu_wren, cpu_stall, cpu_rvalid;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_d, cpu_q;
  logic        io_req, io_wren, io_ack, io_rvalid;
  logic [11:0] io_addr;
  logic [31:0] io_d, io_q;
  logic [11:0] address_dmem;
  logic [31:0] d_dmem, q_dmem;
  logic        wren;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [4096];

  dmem_arbiter #(.IO_STARVE_MAX(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_wren     (cpu_wren),
    .cpu_addr     (cpu_addr),
    .cpu_d        (cpu_d),
    .cpu_stall    (cpu_stall),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_q        (cpu_q),
    .io_req       (io_req),
    .io_wren      (io_wren),
    .io_addr      (io_addr),
    .io_d         (io_d),
    .io_ack       (io_ack),
    .io_rvalid    (io_rvalid),
    .io_q         (io_q),
    .address_dmem (address_dmem),
    .d_dmem       (d_dmem),
    .wren         (wren),
    .q_dmem       (q_dmem)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (wren) mem[address_dmem] <= d_dmem;
    q_dmem <= mem[address_dmem];
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [11:0] a,
                         input logic [31:0] d);
    cpu_req = req; cpu_wren = we; cpu_addr = a; cpu_d = d;
  endtask

  task automatic set_io(input logic req, input logic we, input logic [11:0] a,
                        input logic [31:0] d);
    io_req = req; io_wren = we; io_addr = a; io_d = d;
  endtask

  // Both sides held requesting: expect n_cpu CPU grants, then one forced I/O slot.
  task automatic contend(input string tag, input int n_cpu);
    for (int k = 0; k <= n_cpu; k++) begin
      #1;
      chk_bit({tag, "_ack"}, io_ack, k == n_cpu);
      chk_bit({tag, "_stall"}, cpu_stall, k == n_cpu);
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b1;
    set_cpu(1'b1, 1'b1, 12'h0A5, 32'h0);
    set_io(1'b1, 1'b1, 12'h7FF, 32'h0);
    @(negedge clock);

    // Reset suppresses everything even with both requests present.
    for (int r = 0; r < 2; r++) begin
      #1;
      chk_bit("rst_wren", wren, 1'b0);
      chk_bit("rst_ack", io_ack, 1'b0);
      chk_bit("rst_stall", cpu_stall, 1'b0);
      chk_bit("rst_cpu_rvalid", cpu_rvalid, 1'b0);
      chk_bit("rst_io_rvalid", io_rvalid, 1'b0);
      @(negedge clock);
    end

    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 12'h0A5, 32'h0);
    set_io(1'b0, 1'b0, 12'h7FF, 32'h0);
    #1;
    chk_bit("idle_wren", wren, 1'b0);
    chk_bit("idle_ack", io_ack, 1'b0);
    chk_bit("idle_rvalid", cpu_rvalid, 1'b0);
    @(negedge clock);

    // CPU only: sw then lw, data back two cycles after the store.
    set_cpu(1'b1, 1'b1, 12'h0A5, 32'hDEADBEEF);
    #1;
    chk_bit("cpu_sw_wren", wren, 1'b1);
    chk_bit("cpu_sw_stall", cpu_stall, 1'b0);
    chk_word("cpu_sw_addr", {20'd0, address_dmem}, 32'h0A5);
    chk_word("cpu_sw_data", d_dmem, 32'hDEADBEEF);
    @(negedge clock);
    set_cpu(1'b1, 1'b0, 12'h0A5, 32'h0);
    #1;
    chk_bit("cpu_lw_wren", wren, 1'b0);
    chk_bit("cpu_lw_stall", cpu_stall, 1'b0);
    @(negedge clock);
    set_cpu(1'b0, 1'b0, 12'h0A5, 32'h0);
    #1;
    chk_bit("cpu_rvalid", cpu_rvalid, 1'b1);
    chk_bit("cpu_rd_not_io", io_rvalid, 1'b0);
    chk_word("cpu_q", cpu_q, 32'hDEADBEEF);
    @(negedge clock);

    // I/O only: acked in the request cycle.
    set_io(1'b1, 1'b1, 12'h7FF, 32'h12345678);
    #1;
    chk_bit("io_wr_ack", io_ack, 1'b1);
    chk_bit("io_wr_wren", wren, 1'b1);
    chk_word("io_wr_addr", {20'd0, address_dmem}, 32'h7FF);
    chk_word("io_wr_data", d_dmem, 32'h12345678);
    @(negedge clock);
    set_io(1'b1, 1'b0, 12'h7FF, 32'h0);
    #1;
    chk_bit("io_rd_ack", io_ack, 1'b1);
    chk_bit("io_rd_wren", wren, 1'b0);
    @(negedge clock);
    set_io(1'b0, 1'b0, 12'h7FF, 32'h0);
    #1;
    chk_bit("io_rvalid", io_rvalid, 1'b1);
    chk_bit("io_rd_not_cpu", cpu_rvalid, 1'b0);
    chk_word("io_q", io_q, 32'h12345678);
    @(negedge clock);

    // Continuous contention: I/O slot every fifth cycle, read data routed to owner.
    set_cpu(1'b1, 1'b0, 12'h0A5, 32'h0);
    set_io(1'b1, 1'b0, 12'h7FF, 32'h0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_bit("cont_ack", io_ack, (i % 5) == 4);
      chk_bit("cont_stall", cpu_stall, (i % 5) == 4);
      chk_word("cont_addr", {20'd0, address_dmem}, ((i % 5) == 4) ? 32'h7FF : 32'h0A5);
      if (i > 0) begin
        chk_bit("cont_cpu_rvalid", cpu_rvalid, ((i - 1) % 5) != 4);
        chk_bit("cont_io_rvalid", io_rvalid, ((i - 1) % 5) == 4);
        if (((i - 1) % 5) == 4) chk_word("cont_io_q", io_q, 32'h12345678);
        else chk_word("cont_cpu_q", cpu_q, 32'hDEADBEEF);
      end
      @(negedge clock);
    end
    set_cpu(1'b0, 1'b0, 12'h0A5, 32'h0);
    set_io(1'b0, 1'b0, 12'h7FF, 32'h0);
    #1;
    chk_bit("cont_last_io_rvalid", io_rvalid, 1'b1);
    @(negedge clock);

    // Same-address writes at starve_cnt == 4: I/O first, then the frozen CPU sw.
    set_cpu(1'b1, 1'b0, 12'h0A5, 32'h0);
    set_io(1'b1, 1'b1, 12'h100, 32'h11111111);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_bit("same_wait_ack", io_ack, 1'b0);
      @(negedge clock);
    end
    set_cpu(1'b1, 1'b1, 12'h100, 32'h22222222);
    #1;
    chk_bit("same_io_ack", io_ack, 1'b1);
    chk_bit("same_io_stall", cpu_stall, 1'b1);
    chk_bit("same_io_wren", wren, 1'b1);
    chk_word("same_io_d", d_dmem, 32'h11111111);
    @(negedge clock);
    set_io(1'b0, 1'b0, 12'h100, 32'h0);
    #1;
    chk_bit("same_cpu_stall", cpu_stall, 1'b0);
    chk_bit("same_cpu_wren", wren, 1'b1);
    chk_word("same_cpu_d", d_dmem, 32'h22222222);
    @(negedge clock);
    set_cpu(1'b1, 1'b0, 12'h100, 32'h0);
    @(negedge clock);
    set_cpu(1'b0, 1'b0, 12'h100, 32'h0);
    #1;
    chk_bit("same_rd_rvalid", cpu_rvalid, 1'b1);
    chk_word("same_rd_q", cpu_q, 32'h22222222);
    @(negedge clock);

    // Reset the cycle after an I/O read grant: the read is discarded.
    set_io(1'b1, 1'b0, 12'h7FF, 32'h0);
    #1;
    chk_bit("rstrd_ack", io_ack, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 12'h0A5, 32'h0);
    #1;
    chk_bit("rstrd_io_rvalid", io_rvalid, 1'b0);
    chk_bit("rstrd_ack_off", io_ack, 1'b0);
    chk_bit("rstrd_wren", wren, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_bit("rstrd_post_rvalid", cpu_rvalid, 1'b0);
    contend("rstrd_post", 4);

    // Reset with starve_cnt == 3 and a CPU read in flight.
    contend("rstcnt_pre", 4);
    for (int k = 0; k < 3; k++) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_bit("rstcnt_cpu_rvalid", cpu_rvalid, 1'b0);
    chk_bit("rstcnt_stall", cpu_stall, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    contend("rstcnt_post", 4);

    // io_req dropped for one cycle at starve_cnt == 3 restarts the count.
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_bit("drop_pre_ack", io_ack, 1'b0);
      @(negedge clock);
    end
    io_req = 1'b0;
    #1;
    chk_bit("drop_ack", io_ack, 1'b0);
    chk_bit("drop_stall", cpu_stall, 1'b0);
    @(negedge clock);
    io_req = 1'b1;
    contend("drop_post", 4);

    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_io(1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
